// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave (8-bit, MSB first) with RX FIFO, TX holding register and strobe register interface.
// Optional interrupt output is built in when SPI_SLAVE_IRQ_EN is defined.
module spi_slave_regif #(
  parameter int         SYNC_STAGES = 2,
  parameter int         RX_DEPTH    = 4,
  parameter logic [7:0] FILL_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       WR_TX,
  input  logic       WR_CTRL,
  input  logic       DR_STATUS,
  input  logic       DR_RX,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
`ifdef SPI_SLAVE_IRQ_EN
  output logic       irq,
`endif
  output logic       pkt_rec
);

  localparam int         PW     = $clog2(RX_DEPTH);
  localparam logic [2:0] SETTLE = 3'(SYNC_STAGES + 1);
  localparam logic [2:0] FULL   = 3'(RX_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_d, r_cs_d;
  logic [2:0]             r_settle;
  logic                   r_armed;

  state_t      r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx_shift, r_tx_shift;
  logic        r_reload, r_got_byte, r_pkt_rec, r_ferr;
  logic [7:0]  r_tx_hold;
  logic        r_tx_valid, r_unr, r_ovr;
  logic [7:0]  r_mem [RX_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;
  logic [7:0]  r_prdata;

  logic w_sck, w_cs, w_mosi;
  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;
  logic w_start, w_end, w_rise, w_fall, w_tx_load, w_push;
  logic [7:0] w_load_byte, w_push_data, w_status;
  logic w_flush, w_pop, w_full, w_push_ok, w_ovf;
  logic [PW-1:0] w_wr_idx;

  assign w_sck  = r_sck_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  // A CS low that is already present when reset releases is not a frame start.
  assign w_cs_fall  = ~w_cs & r_cs_d & r_armed;
  assign w_cs_rise  = w_cs & ~r_cs_d;

  // CS rise takes priority, so an SCK fall coincident with it ends the frame without a reload.
  assign w_start     = (r_state == S_IDLE) & w_cs_fall;
  assign w_end       = (r_state == S_ACTIVE) & w_cs_rise;
  assign w_rise      = (r_state == S_ACTIVE) & ~w_cs_rise & w_sck_rise;
  assign w_fall      = (r_state == S_ACTIVE) & ~w_cs_rise & w_sck_fall;
  assign w_tx_load   = w_start | (w_fall & r_reload);
  assign w_load_byte = r_tx_valid ? r_tx_hold : FILL_BYTE;
  assign w_push      = w_rise & (r_bit_cnt == 3'd7);
  assign w_push_data = {r_rx_shift[6:0], w_mosi};

  assign w_flush   = WR_CTRL & PWDATA[3];
  assign w_full    = (r_count == FULL);
  assign w_pop     = DR_RX & (r_count != 3'd0);
  assign w_push_ok = w_push & (~w_full | w_pop | w_flush);
  assign w_ovf     = w_push & w_full & ~w_pop & ~w_flush;
  assign w_wr_idx  = w_flush ? {PW{1'b0}} : r_wr_ptr;

  assign w_status = {r_ferr, r_unr, r_ovr, (r_state == S_ACTIVE), ~r_tx_valid, r_count};

  assign MISO    = (r_state == S_ACTIVE) & r_tx_shift[7];
  assign PRDATA  = r_prdata;
  assign pkt_rec = r_pkt_rec;

  // Input synchronisers, edge history and post-reset CS arming.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck_sync  <= {SYNC_STAGES{1'b0}};
      r_cs_sync   <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= {SYNC_STAGES{1'b0}};
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
      r_settle    <= 3'd0;
      r_armed     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs;
      if (r_settle != SETTLE) r_settle <= r_settle + 3'd1;
      if ((r_settle == SETTLE) && w_cs) r_armed <= 1'b1;
    end
  end

  // Frame FSM: bit counting, shift registers, frame error and packet pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= 8'h00;
      r_tx_shift <= 8'h00;
      r_reload   <= 1'b0;
      r_got_byte <= 1'b0;
      r_pkt_rec  <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_pkt_rec <= 1'b0;
      if (WR_CTRL && PWDATA[2]) r_ferr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_ACTIVE;
            r_bit_cnt  <= 3'd0;
            r_reload   <= 1'b0;
            r_got_byte <= 1'b0;
            r_tx_shift <= w_load_byte;
          end
        end
        S_ACTIVE: begin
          if (w_end) begin
            r_state <= S_IDLE;
            if (r_bit_cnt != 3'd0) r_ferr <= 1'b1;
            r_pkt_rec  <= r_got_byte;
            r_got_byte <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_reload   <= 1'b0;
          end else begin
            if (w_rise) begin
              r_rx_shift <= w_push_data;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_reload   <= 1'b1;
                r_got_byte <= 1'b1;
              end
            end
            if (w_fall) begin
              if (r_reload) begin
                r_tx_shift <= w_load_byte;
                r_reload   <= 1'b0;
              end else begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // TX holding register and underrun flag; a host write after a load leaves the new byte pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_hold  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_unr      <= 1'b0;
    end else begin
      if (WR_CTRL && PWDATA[1]) r_unr <= 1'b0;
      if (w_tx_load) begin
        if (r_tx_valid) r_tx_valid <= 1'b0;
        else            r_unr      <= 1'b1;
      end
      if (WR_TX) begin
        r_tx_hold  <= PWDATA;
        r_tx_valid <= 1'b1;
      end
    end
  end

  // RX FIFO pointers, occupancy and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= 3'd0;
      r_ovr    <= 1'b0;
    end else begin
      if (WR_CTRL && PWDATA[0]) r_ovr <= 1'b0;
      if (w_ovf) r_ovr <= 1'b1;
      if (w_flush) begin
        r_rd_ptr <= {PW{1'b0}};
        r_wr_ptr <= w_push_ok ? PW'(1) : {PW{1'b0}};
        r_count  <= {2'b00, w_push_ok};
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + {2'b00, w_push_ok} - {2'b00, w_pop};
      end
    end
  end

  // RX FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[w_wr_idx] <= w_push_data;
  end

  // Registered read data; the FIFO read has priority over status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prdata <= 8'h00;
    end else if (DR_RX) begin
      r_prdata <= (r_count != 3'd0) ? r_mem[r_rd_ptr] : 8'h00;
    end else if (DR_STATUS) begin
      r_prdata <= w_status;
    end
  end

`ifdef SPI_SLAVE_IRQ_EN
  logic r_ie, r_irq;
  assign irq = r_irq;

  // Interrupt enable and registered interrupt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (WR_CTRL) r_ie <= PWDATA[7];
      r_irq <= r_ie & ((r_count != 3'd0) | r_ovr | r_unr | r_ferr);
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_regif.sv
// Directed bench for spi_slave_regif: a transaction-level model of the FIFO, flags and TX
// byte sequence, checked against PRDATA/pkt_rec every cycle and MISO at every master sample.
module tb_spi_slave_regif;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, SCK, CS, MOSI, MISO, WR_TX, WR_CTRL, DR_STATUS, DR_RX, pkt_rec;
  logic [7:0] PWDATA, PRDATA;
`ifdef SPI_SLAVE_IRQ_EN
  logic irq;
`endif

  always #5 clk = ~clk;

  spi_slave_regif dut (
    .clk(clk), .rst(rst), .SCK(SCK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .WR_TX(WR_TX), .WR_CTRL(WR_CTRL), .DR_STATUS(DR_STATUS), .DR_RX(DR_RX),
    .PWDATA(PWDATA), .PRDATA(PRDATA),
`ifdef SPI_SLAVE_IRQ_EN
    .irq(irq),
`endif
    .pkt_rec(pkt_rec)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] m_q[$];
  bit         m_ovr, m_unr, m_ferr, m_tv;
  logic [7:0] m_hold;
  logic [7:0] exp_prdata;
  bit         chk_en = 1'b0;
  int         pkt_cnt = 0;
  logic       pkt_prev = 1'b0;
  logic [7:0] mosi_bytes[$];
  logic [7:0] miso_bytes[$];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_ferr, m_unr, m_ovr, 1'b0, ~m_tv, 3'(m_q.size())};
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_ovr = 1'b0; m_unr = 1'b0; m_ferr = 1'b0; m_tv = 1'b0; m_hold = 8'h00;
  endtask

  task automatic m_load(output logic [7:0] b);
    if (m_tv) begin
      b = m_hold; m_tv = 1'b0;
    end else begin
      b = 8'hFF; m_unr = 1'b1;
    end
  endtask

  task automatic m_push(input logic [7:0] b);
    if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model: read data and single-cycle pkt_rec.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check8("prdata_model", PRDATA, exp_prdata);
        check8("pkt_width", {7'b0, pkt_rec & pkt_prev}, 8'h00);
        if (pkt_rec === 1'b1) pkt_cnt++;
      end
      pkt_prev = pkt_rec;
    end
  end

  task automatic wr_tx(input logic [7:0] b);
    tick(1);
    WR_TX = 1'b1; PWDATA = b; m_hold = b; m_tv = 1'b1;
    tick(1);
    WR_TX = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [7:0] b);
    tick(1);
    WR_CTRL = 1'b1; PWDATA = b;
    if (b[0]) m_ovr = 1'b0;
    if (b[1]) m_unr = 1'b0;
    if (b[2]) m_ferr = 1'b0;
    if (b[3]) m_q.delete();
    tick(1);
    WR_CTRL = 1'b0;
  endtask

  task automatic rd(input bit rx, input bit st);
    logic [7:0] v;
    tick(1);
    DR_RX = rx; DR_STATUS = st;
    if (rx) begin
      if (m_q.size() != 0) v = m_q.pop_front();
      else v = 8'h00;
    end else begin
      v = m_status();
    end
    tick(1);
    DR_RX = 1'b0; DR_STATUS = 1'b0;
    exp_prdata = v;
  endtask

  task automatic expect_pr(input string name, input logic [7:0] v);
    @(negedge clk);
    check8(name, PRDATA, v);
  endtask

  // One CS-framed transfer of nbits bits from mosi_bytes; the last SCK fall coincides with CS rise.
  task automatic frame(input int nbits);
    logic [7:0] cur, mb;
    int pk0;
    miso_bytes.delete();
    pk0 = pkt_cnt;
    mb = 8'h00;
    m_load(cur);
    CS = 1'b0; SCK = 1'b0; MOSI = mosi_bytes[0][7];
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      SCK = 1'b1;
      tick(4);
      check8("miso_bit", {7'b0, MISO}, {7'b0, cur[7 - (i % 8)]});
      mb = {mb[6:0], MISO};
      if (i % 8 == 7) begin
        miso_bytes.push_back(mb);
        m_push(mosi_bytes[i / 8]);
        if (i < nbits - 1) m_load(cur);
      end
      if (i == nbits - 1) begin
        SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
      end else begin
        SCK = 1'b0; MOSI = mosi_bytes[(i + 1) / 8][7 - ((i + 1) % 8)];
      end
      tick(4);
    end
    if (nbits % 8 != 0) m_ferr = 1'b1;
    tick(6);
    check8("pkt_rec_count", 8'(pkt_cnt - pk0), (nbits >= 8) ? 8'd1 : 8'd0);
    check8("miso_idle", {7'b0, MISO}, 8'h00);
  endtask

  initial begin
    int pk0;
    rst = 1'b1; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    WR_TX = 1'b0; WR_CTRL = 1'b0; DR_STATUS = 1'b0; DR_RX = 1'b0; PWDATA = 8'h00;
    m_reset();
    tick(3);
    rst = 1'b0;
    exp_prdata = 8'h00;
    @(negedge clk);
    check8("reset_prdata", PRDATA, 8'h00);
    check8("reset_miso", {7'b0, MISO}, 8'h00);
    check8("reset_pkt_rec", {7'b0, pkt_rec}, 8'h00);
    chk_en = 1'b1;
    tick(10);

    // Single byte with a loaded TX byte
    wr_tx(8'hA5);
    mosi_bytes = '{8'h3C};
    frame(8);
    check8("miso_byte_a5", miso_bytes[0], 8'hA5);
    rd(1'b0, 1'b1); expect_pr("status_one_byte", 8'h09);
    rd(1'b1, 1'b0); expect_pr("rx_3c", 8'h3C);

    // Two bytes with nothing loaded: fill bytes and underrun
    mosi_bytes = '{8'h11, 8'h22};
    frame(16);
    check8("miso_fill0", miso_bytes[0], 8'hFF);
    check8("miso_fill1", miso_bytes[1], 8'hFF);
    rd(1'b0, 1'b1); expect_pr("status_unr", 8'h4A);
    wr_ctrl(8'h02);
    rd(1'b0, 1'b1); expect_pr("status_unr_clr", 8'h0A);
    rd(1'b1, 1'b0); expect_pr("rx_11", 8'h11);
    rd(1'b1, 1'b0); expect_pr("rx_22", 8'h22);

    // Overrun: five bytes into a four-entry FIFO
    mosi_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    frame(40);
    rd(1'b0, 1'b1); expect_pr("status_ovr", 8'h6C);
    for (int k = 1; k <= 4; k++) begin
      rd(1'b1, 1'b0); expect_pr("rx_seq", 8'(k));
    end
    rd(1'b1, 1'b0); expect_pr("rx_empty", 8'h00);
    wr_ctrl(8'h03);

    // Partial frame then a good frame
    wr_tx(8'h77);
    mosi_bytes = '{8'hC3};
    frame(5);
    rd(1'b0, 1'b1); expect_pr("status_ferr", 8'h88);
    wr_tx(8'h99);
    mosi_bytes = '{8'hE7};
    frame(8);
    check8("miso_byte_99", miso_bytes[0], 8'h99);
    rd(1'b0, 1'b1); expect_pr("status_after_ferr", 8'h89);
    rd(1'b1, 1'b0); expect_pr("rx_e7", 8'hE7);
    wr_ctrl(8'h04);

    // Both read strobes: FIFO read wins, empty returns zero
    rd(1'b1, 1'b1); expect_pr("both_strobes", 8'h00);

    // Flush
    wr_tx(8'hAA);
    mosi_bytes = '{8'h42};
    frame(8);
    rd(1'b0, 1'b1); expect_pr("status_pre_flush", 8'h09);
    wr_ctrl(8'h08);
    rd(1'b0, 1'b1); expect_pr("status_flushed", 8'h08);

    // Reset in the middle of a byte; the remainder of that frame is ignored
    mosi_bytes = '{8'h33};
    frame(8);
    rd(1'b0, 1'b1); expect_pr("status_pre_rst", 8'h49);
    pk0 = pkt_cnt;
    CS = 1'b0; SCK = 1'b0; MOSI = 1'b1;
    tick(4);
    for (int i = 0; i < 3; i++) begin
      SCK = 1'b1; tick(4); SCK = 1'b0; tick(4);
    end
    rst = 1'b1; chk_en = 1'b0;
    m_reset();
    tick(2);
    rst = 1'b0;
    exp_prdata = 8'h00;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      SCK = 1'b1; tick(4); SCK = 1'b0; tick(4);
    end
    CS = 1'b1;
    tick(12);
    check8("rst_prdata", PRDATA, 8'h00);
    check8("rst_no_pkt", 8'(pkt_cnt - pk0), 8'd0);
    rd(1'b0, 1'b1); expect_pr("status_post_rst", 8'h08);
    wr_tx(8'hC9);
    mosi_bytes = '{8'h5A};
    frame(8);
    check8("miso_byte_c9", miso_bytes[0], 8'hC9);
    rd(1'b0, 1'b1); expect_pr("status_post_rst_frame", 8'h09);
    rd(1'b1, 1'b0); expect_pr("rx_5a", 8'h5A);
    rd(1'b1, 1'b0); expect_pr("rx_post_rst_empty", 8'h00);

`ifdef SPI_SLAVE_IRQ_EN
    // Interrupt follows FIFO occupancy when enabled
    wr_ctrl(8'h0F);
    wr_ctrl(8'h80);
    tick(2);
    check8("irq_idle", {7'b0, irq}, 8'h00);
    wr_tx(8'h12);
    mosi_bytes = '{8'h6E};
    frame(8);
    check8("irq_set", {7'b0, irq}, 8'h01);
    rd(1'b1, 1'b0);
    @(negedge clk);
    check8("irq_lag", {7'b0, irq}, 8'h01);
    check8("rx_6e", PRDATA, 8'h6E);
    tick(1);
    @(negedge clk);
    check8("irq_clr", {7'b0, irq}, 8'h00);
`endif

    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
